// File: rtl/alu_frame_pkg.sv
// Shared types and constants for the ALU command front-end.
// Frame command bytes, data widths and the controller state set.
package alu_frame_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FUN_WIDTH  = 4;
    localparam int OUT_WIDTH  = 2 * DATA_WIDTH;

    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_FUN,
        S_ISSUE,
        S_WAIT_RES,
        S_SEND_LO,
        S_GAP_LO,
        S_SEND_HI,
        S_GAP_HI
    } alu_frame_state_e;

endpackage

// File: rtl/alu_frame_ctrl.sv
// Byte-frame parser feeding the ALU; returns the 16-bit result as two
// transmit bytes, LSB first, honouring the transmitter busy flag.
module alu_frame_ctrl
    import alu_frame_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int FW = FUN_WIDTH,
    parameter int OW = OUT_WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] RX_P_DATA,
    input  logic          RX_D_VLD,
    output logic [DW-1:0] ALU_A,
    output logic [DW-1:0] ALU_B,
    output logic [FW-1:0] ALU_FUN,
    output logic          ALU_EN,
    input  logic [OW-1:0] ALU_OUT,
    input  logic          OUT_VALID,
    output logic [DW-1:0] TX_P_DATA,
    output logic          TX_D_VLD,
    input  logic          TX_BUSY,
    output logic          CMD_ERR
);

    alu_frame_state_e state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [FW-1:0] fun_q, fun_d;
    logic [OW-1:0] res_q, res_d;
    logic [DW-1:0] txd_q, txd_d;
    logic          err_q, err_d;
    logic          alu_en;
    logic          tx_vld;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            res_q   <= '0;
            txd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            res_q   <= res_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        res_d   = res_q;
        txd_d   = txd_q;
        err_d   = 1'b0;
        alu_en  = 1'b0;
        tx_vld  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OP) begin
                        state_d = S_GET_A;
                    end else if (RX_P_DATA == CMD_ALU_NOP) begin
                        state_d = S_GET_FUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GET_A: begin
                if (RX_D_VLD) begin
                    a_d     = RX_P_DATA;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (RX_D_VLD) begin
                    b_d     = RX_P_DATA;
                    state_d = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[FW-1:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_en  = 1'b1;
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (OUT_VALID) begin
                    res_d   = ALU_OUT;
                    state_d = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (!TX_BUSY) begin
                    tx_vld  = 1'b1;
                    txd_d   = res_q[DW-1:0];
                    state_d = S_GAP_LO;
                end
            end
            S_GAP_LO: state_d = S_SEND_HI;
            S_SEND_HI: begin
                if (!TX_BUSY) begin
                    tx_vld  = 1'b1;
                    txd_d   = res_q[OW-1:DW];
                    state_d = S_GAP_HI;
                end
            end
            S_GAP_HI: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobed byte goes out in the same cycle; otherwise the last byte holds.
    assign TX_P_DATA = txd_d;
    assign TX_D_VLD  = tx_vld;
    assign ALU_EN    = alu_en;
    assign ALU_A     = a_q;
    assign ALU_B     = b_q;
    assign ALU_FUN   = fun_q;
    assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Bench for alu_frame_ctrl: ALU and transmitter responders plus a
// frame-level reference model of stored operands and returned bytes.
module tb_alu_frame_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  ALU_A, ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT = 16'h0;
    logic        OUT_VALID = 1'b0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY = 1'b0;
    logic        CMD_ERR;

    alu_frame_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_q[$];
    int tx_cyc[$];
    int en_cyc[$];
    logic [7:0] exp_q[$];
    int err_cnt = 0;
    int viol = 0;
    int cyc = 0;
    int busy_cnt = 0;
    bit force_busy = 1'b0;
    bit rand_busy = 1'b0;
    int strobe_cyc = 0;
    logic [7:0] ref_a = 8'h0;
    logic [7:0] ref_b = 8'h0;
    logic [3:0] ref_fun = 4'h0;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (f)
            4'd0:    return wa + wb;
            4'd1:    return wa - wb;
            4'd2:    return wa * wb;
            4'd3:    return (b != 0) ? wa / wb : 16'hFFFF;
            4'd4:    return wa & wb;
            4'd5:    return wa | wb;
            4'd6:    return wa ^ wb;
            4'd7:    return {a, b};
            default: return {b, a};
        endcase
    endfunction

    // ALU responder: registered result one cycle after the enable.
    always @(posedge CLK) begin
        OUT_VALID <= ALU_EN;
        ALU_OUT   <= alu_f(ALU_A, ALU_B, ALU_FUN);
    end

    // Transmitter responder and protocol monitor.
    initial begin
        logic prev_vld, prev_en;
        logic [7:0] last_tx;
        prev_vld = 1'b0;
        prev_en  = 1'b0;
        last_tx  = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            TX_BUSY = force_busy || (busy_cnt > 0);
            @(negedge CLK);
            cyc++;
            if (!RST) last_tx = 8'h00;
            if (TX_D_VLD) begin
                if (TX_BUSY) viol++;
                if (prev_vld) viol++;
                tx_q.push_back(TX_P_DATA);
                tx_cyc.push_back(cyc);
                last_tx = TX_P_DATA;
                if (rand_busy) busy_cnt = $urandom_range(4, 1);
            end else if (RST && TX_P_DATA !== last_tx) begin
                viol++;
            end
            if (ALU_EN) begin
                if (prev_en) viol++;
                en_cyc.push_back(cyc);
            end
            if (CMD_ERR) err_cnt++;
            prev_vld = TX_D_VLD;
            prev_en  = ALU_EN;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        RX_P_DATA  = b;
        RX_D_VLD   = 1'b1;
        strobe_cyc = cyc + 1;
        @(posedge CLK);
        #1;
        RX_D_VLD = 1'b0;
    endtask

    task automatic send_frame(input bit nop, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] fun);
        logic [15:0] r;
        if (nop) begin
            send_byte(8'hDD);
        end else begin
            send_byte(8'hCC);
            send_byte(a);
            send_byte(b);
            ref_a = a;
            ref_b = b;
        end
        send_byte(fun);
        ref_fun = fun[3:0];
        r = alu_f(ref_a, ref_b, ref_fun);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (tx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge CLK);
    endtask

    task automatic clear_logs();
        tx_q.delete();
        tx_cyc.delete();
        en_cyc.delete();
        exp_q.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        RX_P_DATA = 8'h55;
        RX_D_VLD = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({ALU_A, ALU_B, ALU_FUN} !== 20'h0) begin
            errors++;
            $display("FAIL reset_operands got %h %h %h want 0", ALU_A, ALU_B, ALU_FUN);
        end
        checks++;
        if ({ALU_EN, TX_D_VLD, CMD_ERR, TX_P_DATA} !== 11'h0) begin
            errors++;
            $display("FAIL reset_strobes en=%b vld=%b err=%b tx=%h want 0",
                     ALU_EN, TX_D_VLD, CMD_ERR, TX_P_DATA);
        end
        RX_D_VLD = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        ref_a = 8'h0;
        ref_b = 8'h0;
        repeat (2) @(posedge CLK);
        clear_logs();
    endtask

    task automatic test_basic();
        bit ok;
        int t;
        clear_logs();
        rand_busy = 1'b0;
        send_frame(1'b0, 8'h05, 8'h03, 8'h00);
        t = strobe_cyc;
        wait_tx(2, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout got %0d bytes want 2", tx_q.size());
        end
        checks++;
        if (ALU_A !== 8'h05 || ALU_B !== 8'h03 || ALU_FUN !== 4'h0) begin
            errors++;
            $display("FAIL basic_operands got %h %h %h want 05 03 0", ALU_A, ALU_B, ALU_FUN);
        end
        checks++;
        if (en_cyc.size() != 1 || en_cyc[0] != t + 1) begin
            errors++;
            $display("FAIL basic_alu_en got %0d pulses want 1 at cycle %0d", en_cyc.size(), t + 1);
        end
        checks++;
        if (tx_q.size() != 2 || tx_q[0] !== 8'h08 || tx_q[1] !== 8'h00) begin
            errors++;
            $display("FAIL basic_bytes got %p want 08 00", tx_q);
        end
        checks++;
        if (tx_cyc.size() != 2 || tx_cyc[0] != t + 3 || tx_cyc[1] != t + 5) begin
            errors++;
            $display("FAIL basic_latency got %p want %0d %0d", tx_cyc, t + 3, t + 5);
        end
    endtask

    task automatic test_nop_reuse();
        bit ok;
        clear_logs();
        rand_busy = 1'b1;
        send_frame(1'b0, 8'h0F, 8'h03, 8'h02);
        wait_tx(2, 50, ok);
        send_frame(1'b1, 8'h00, 8'h00, 8'h03);
        wait_tx(4, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL nop_timeout got %0d bytes want 4", tx_q.size());
        end
        checks++;
        if (tx_q.size() != 4 || tx_q[0] !== 8'h2D || tx_q[1] !== 8'h00 ||
            tx_q[2] !== 8'h05 || tx_q[3] !== 8'h00) begin
            errors++;
            $display("FAIL nop_bytes got %p want 2D 00 05 00", tx_q);
        end
        checks++;
        if (ALU_A !== 8'h0F || ALU_B !== 8'h03 || ALU_FUN !== 4'h3) begin
            errors++;
            $display("FAIL nop_operands got %h %h %h want 0F 03 3", ALU_A, ALU_B, ALU_FUN);
        end
    endtask

    task automatic test_cmd_err();
        bit ok;
        clear_logs();
        send_byte(8'h55);
        repeat (4) @(posedge CLK);
        checks++;
        if (err_cnt != 1 || en_cyc.size() != 0) begin
            errors++;
            $display("FAIL cmd_err got %0d err cycles %0d en want 1 0", err_cnt, en_cyc.size());
        end
        send_frame(1'b0, 8'hFF, 8'hFF, 8'h00);
        wait_tx(2, 50, ok);
        checks++;
        if (tx_q.size() != 2 || tx_q[0] !== 8'hFE || tx_q[1] !== 8'h01) begin
            errors++;
            $display("FAIL cmd_err_follow got %p want FE 01", tx_q);
        end
    endtask

    task automatic test_busy();
        bit ok;
        clear_logs();
        rand_busy  = 1'b0;
        force_busy = 1'b1;
        send_frame(1'b0, 8'h21, 8'h13, 8'h02);
        repeat (22) @(posedge CLK);
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL busy_hold got %0d strobes want 0", tx_q.size());
        end
        force_busy = 1'b0;
        wait_tx(2, 50, ok);
        checks++;
        if (tx_q.size() != 2 || tx_q[0] !== exp_q[0] || tx_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL busy_bytes got %p want %p", tx_q, exp_q);
        end
        checks++;
        if (tx_cyc.size() != 2 || tx_cyc[1] - tx_cyc[0] < 2) begin
            errors++;
            $display("FAIL busy_gap got %p want gap >= 2", tx_cyc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        send_byte(8'hCC);
        send_byte(8'h07);
        checks++;
        if (ALU_A !== 8'h07) begin
            errors++;
            $display("FAIL mid_pre got ALU_A=%h want 07", ALU_A);
        end
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        checks++;
        if ({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D_VLD, CMD_ERR, TX_P_DATA} !== 31'h0) begin
            errors++;
            $display("FAIL mid_reset got %h %h %h %b %b %b %h want 0",
                     ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D_VLD, CMD_ERR, TX_P_DATA);
        end
        @(negedge CLK);
        RST = 1'b1;
        ref_a = 8'h0;
        ref_b = 8'h0;
        repeat (2) @(posedge CLK);
        clear_logs();
        send_frame(1'b1, 8'h00, 8'h00, 8'h00);
        wait_tx(2, 50, ok);
        checks++;
        if (tx_q.size() != 2 || tx_q[0] !== 8'h00 || tx_q[1] !== 8'h00 || err_cnt != 0) begin
            errors++;
            $display("FAIL mid_after got %p err=%0d want 00 00 err=0", tx_q, err_cnt);
        end
    endtask

    task automatic test_extra_rx();
        bit ok;
        logic [7:0] junk[4] = '{8'h55, 8'hCC, 8'hDD, 8'h12};
        clear_logs();
        force_busy = 1'b1;
        send_frame(1'b0, 8'h9A, 8'h47, 8'h01);
        foreach (junk[i]) send_byte(junk[i]);
        force_busy = 1'b0;
        wait_tx(2, 50, ok);
        send_frame(1'b0, 8'h31, 8'h0B, 8'h06);
        wait_tx(4, 50, ok);
        checks++;
        if (err_cnt != 0 || en_cyc.size() != 2) begin
            errors++;
            $display("FAIL extra_rx got err=%0d en=%0d want 0 2", err_cnt, en_cyc.size());
        end
        checks++;
        if (tx_q != exp_q) begin
            errors++;
            $display("FAIL extra_bytes got %p want %p", tx_q, exp_q);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n_err;
        clear_logs();
        rand_busy = 1'b1;
        n_err = 0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(5, 0) == 0) begin
                send_byte(8'h40 + 8'($urandom_range(15, 0)));
                n_err++;
                repeat (2) @(posedge CLK);
            end
            send_frame(1'($urandom_range(2, 0) == 0), 8'($urandom), 8'($urandom), 8'($urandom));
            wait_tx(exp_q.size(), 80, ok);
            checks++;
            if (!ok || ALU_A !== ref_a || ALU_B !== ref_b || ALU_FUN !== ref_fun) begin
                errors++;
                $display("FAIL rand_frame %0d ok=%b got %h %h %h want %h %h %h",
                         i, ok, ALU_A, ALU_B, ALU_FUN, ref_a, ref_b, ref_fun);
            end
        end
        checks++;
        if (tx_q != exp_q) begin
            errors++;
            $display("FAIL rand_bytes got %0d bytes want %0d", tx_q.size(), exp_q.size());
        end
        checks++;
        if (err_cnt != n_err || en_cyc.size() != 24) begin
            errors++;
            $display("FAIL rand_counts got err=%0d en=%0d want %0d 24",
                     err_cnt, en_cyc.size(), n_err);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL protocol got %0d violations want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nop_reuse();
        test_cmd_err();
        test_busy();
        test_reset_mid();
        test_extra_rx();
        test_random();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
